// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - First-word fall-through AXI-Stream FIFO with sideband fields
// Optional per-entry tstrb/tkeep storage is enabled by defining AXIS_FIFO_STRB_KEEP_EN.
module axis_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [7:0]                        s_tid,
    input  logic [3:0]                        s_tdest,
    input  logic                              s_tlast,
    input  logic [DATA_WIDTH/8-1:0]           s_tstrb,
    input  logic [DATA_WIDTH/8-1:0]           s_tkeep,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [7:0]                        m_tid,
    output logic [3:0]                        m_tdest,
    output logic                              m_tlast,
    output logic [DATA_WIDTH/8-1:0]           m_tstrb,
    output logic [DATA_WIDTH/8-1:0]           m_tkeep,
    output logic [$clog2(DEPTH):0]            count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = DATA_WIDTH / 8;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    logic                  tready_q;
    logic                  push;
    logic                  pop;

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [7:0]            mem_id   [DEPTH];
    logic [3:0]            mem_dest [DEPTH];
    logic                  mem_last [DEPTH];

    assign push          = s_axis_tvalid & tready_q;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = (count_q != '0);
    assign count         = count_q;

    always_comb begin
        count_next = count_q + CW'(push) - CW'(pop);
    end

    // Ready is registered from next-cycle occupancy so it tracks count < DEPTH exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            tready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q  <= count_next;
            tready_q <= (count_next < FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= s_axis_tdata;
            mem_id[wr_ptr]   <= s_tid;
            mem_dest[wr_ptr] <= s_tdest;
            mem_last[wr_ptr] <= s_tlast;
        end
    end

    assign m_axis_tdata = mem_data[rd_ptr];
    assign m_tid        = mem_id[rd_ptr];
    assign m_tdest      = mem_dest[rd_ptr];
    assign m_tlast      = mem_last[rd_ptr];

`ifdef AXIS_FIFO_STRB_KEEP_EN
    logic [KW-1:0] mem_strb [DEPTH];
    logic [KW-1:0] mem_keep [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_strb[wr_ptr] <= s_tstrb;
            mem_keep[wr_ptr] <= s_tkeep;
        end
    end

    assign m_tstrb = mem_strb[rd_ptr];
    assign m_tkeep = mem_keep[rd_ptr];
`else
    logic unused_strb_keep;

    assign unused_strb_keep = &{1'b0, s_tstrb, s_tkeep};
    assign m_tstrb          = {KW{1'b1}};
    assign m_tkeep          = {KW{1'b1}};
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// tb/tb_axis_fifo.sv - Directed self-checking bench for axis_fifo (DATA_WIDTH=8, DEPTH=4)
module tb_axis_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] s_tid;
    logic [3:0] s_tdest;
    logic       s_tlast;
    logic [0:0] s_tstrb;
    logic [0:0] s_tkeep;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [7:0] m_tid;
    logic [3:0] m_tdest;
    logic       m_tlast;
    logic [0:0] m_tstrb;
    logic [0:0] m_tkeep;
    logic [2:0] count;

    int vectors = 0;
    int miscompares = 0;

    axis_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_tid         (s_tid),
        .s_tdest       (s_tdest),
        .s_tlast       (s_tlast),
        .s_tstrb       (s_tstrb),
        .s_tkeep       (s_tkeep),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_tid         (m_tid),
        .m_tdest       (m_tdest),
        .m_tlast       (m_tlast),
        .m_tstrb       (m_tstrb),
        .m_tkeep       (m_tkeep),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] next_in;
        logic [7:0] held;
        logic       exp_push;
        logic       exp_pop;
        logic       stalled;
        int         n_in;

        rst = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_tid = '0;
        s_tdest = '0;
        s_tlast = 1'b0;
        s_tstrb = 1'b0;
        s_tkeep = 1'b0;
        m_axis_tready = 1'b0;

        step();
        step();
        chk("reset_count", count, 0);
        chk("reset_mvalid", m_axis_tvalid, 0);
        chk("reset_sready", s_axis_tready, 0);
        rst = 1'b0;
        step();
        chk("post_reset_sready", s_axis_tready, 1);
        chk("post_reset_count", count, 0);

        // Single beat, first-word fall-through
        s_axis_tdata = 8'hA5;
        s_tlast = 1'b1;
        s_tid = 8'h03;
        s_tdest = 4'h5;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        s_tlast = 1'b0;
        chk("single_mvalid", m_axis_tvalid, 1);
        chk("single_tdata", m_axis_tdata, 8'hA5);
        chk("single_tlast", m_tlast, 1);
        chk("single_tid", m_tid, 8'h03);
        chk("single_tdest", m_tdest, 4'h5);
        chk("single_count1", count, 1);
`ifdef AXIS_FIFO_STRB_KEEP_EN
        chk("single_tkeep", m_tkeep, 0);
        chk("single_tstrb", m_tstrb, 0);
`else
        chk("single_tkeep", m_tkeep, 1);
        chk("single_tstrb", m_tstrb, 1);
`endif
        step();
        chk("single_count0", count, 0);
        chk("single_mvalid0", m_axis_tvalid, 0);

        // Fill to full with master stalled, then offer a fifth beat
        m_axis_tready = 1'b0;
        s_tkeep = 1'b1;
        s_tstrb = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            s_axis_tdata = 8'(i);
            s_tid = 8'h10 + 8'(i);
            s_axis_tvalid = 1'b1;
            step();
        end
        chk("full_count", count, 4);
        chk("full_sready", s_axis_tready, 0);
        s_axis_tdata = 8'h05;
        s_tid = 8'h15;
        step();
        s_axis_tvalid = 1'b0;
        chk("full_reject_count", count, 4);
        chk("full_head_held", m_axis_tdata, 8'h01);
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_tdata", m_axis_tdata, 32'(i));
            chk("drain_tid", m_tid, 32'(8'h10 + 8'(i)));
            step();
        end
        chk("drain_count", count, 0);
        chk("drain_mvalid", m_axis_tvalid, 0);

        // Full FIFO under continuous push and pop
        m_axis_tready = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) begin
            s_axis_tdata = 8'h10 + 8'(i);
            s_axis_tvalid = 1'b1;
            q.push_back(8'h10 + 8'(i));
            step();
        end
        chk("stream_full_count", count, 4);
        next_in = 8'h20;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_axis_tdata = next_in;
            s_axis_tvalid = 1'b1;
            chk("stream_sready", s_axis_tready, (k == 0) ? 0 : 1);
            chk("stream_count", count, (k == 0) ? 4 : 3);
            chk("stream_tdata", m_axis_tdata, q[0]);
            exp_push = (q.size() < 4);
            exp_pop = (q.size() > 0);
            step();
            if (exp_pop) void'(q.pop_front());
            if (exp_push) begin
                q.push_back(next_in);
                next_in++;
            end
        end
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < 6 && q.size() > 0; k++) begin
            chk("stream_drain", m_axis_tdata, q[0]);
            step();
            void'(q.pop_front());
        end
        chk("stream_empty", m_axis_tvalid, 0);

        // Six beats with alternating master ready, pointers wrap
        n_in = 0;
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 24 && (n_in < 6 || q.size() > 0); c++) begin
            s_axis_tvalid = (n_in < 6);
            s_axis_tdata = 8'(n_in);
            m_axis_tready = c[0];
            chk("wrap_count", count, q.size());
            if (q.size() > 0) begin
                chk("wrap_tdata", m_axis_tdata, q[0]);
                if (stalled) chk("wrap_stall_hold", m_axis_tdata, held);
            end
            exp_push = s_axis_tvalid && (q.size() < 4);
            exp_pop = m_axis_tready && (q.size() > 0);
            stalled = !m_axis_tready && (q.size() > 0);
            held = m_axis_tdata;
            step();
            if (exp_pop) void'(q.pop_front());
            if (exp_push) begin
                q.push_back(8'(n_in));
                n_in++;
            end
        end
        chk("wrap_all_in", n_in, 6);
        chk("wrap_all_out", q.size(), 0);
        s_axis_tvalid = 1'b0;

        // Reset mid-operation discards contents
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata = 8'hC0 + 8'(i);
            s_axis_tvalid = 1'b1;
            step();
        end
        s_axis_tvalid = 1'b0;
        chk("pre_rst_count", count, 3);
        rst = 1'b1;
        step();
        chk("rst_count", count, 0);
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_sready", s_axis_tready, 0);
        rst = 1'b0;
        step();
        chk("after_rst_sready", s_axis_tready, 1);
        chk("after_rst_mvalid", m_axis_tvalid, 0);
        s_axis_tdata = 8'h77;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        chk("after_rst_tdata", m_axis_tdata, 8'h77);
        chk("after_rst_count", count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
